// File: rtl/soc_io_ctrl.sv
// soc_io_ctrl: memory-mapped IO slave between the core load/store path and board pins.
//   Operand switches are synchronised and debounced, the result register drives pins,
//   and cycle / load-branch-conflict / retire counters measure IPC in hardware.
// Ports: base_clk/reset (async, active-low); opr1_pin/opr2_pin raw switches; result pins;
//   io_addr/io_wdata/io_we/io_re request, io_rdata/io_ready fixed 1-cycle response;
//   lb_conflict/retire event inputs for the counters.
// Latency 1 cycle per request, io_ready pulses once per request; no back-pressure.

// Per-bus synchroniser + debouncer. opr_o updates only after the synchronised
// value has held still long enough; shorter glitches are absorbed.
module soc_io_deb #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] pin_i,
    output logic [7:0] opr_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] SAT = CW'(DEB_CYCLES);

    logic [7:0]    s1_q, s2_q, prev_q, opr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable, load;

    always_comb begin
        stable = (s2_q == prev_q);
        if (!stable)
            cnt_d = '0;
        else if (cnt_q == SAT)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CW'(1);
        // Load on the cycle the count reaches DEB_CYCLES-1; saturation keeps it one-shot.
        load = stable && (cnt_d == SAT - CW'(1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
            cnt_q  <= '0;
            opr_q  <= '0;
        end else begin
            s1_q   <= pin_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            cnt_q  <= cnt_d;
            if (load)
                opr_q <= s2_q;
        end
    end

    assign opr_o = opr_q;
endmodule

module soc_io_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_4000,
    parameter int          DEB_CYCLES = 4,
    parameter int          CNT_W      = 32
) (
    input  logic        base_clk,
    input  logic        reset,
    input  logic [7:0]  opr1_pin,
    input  logic [7:0]  opr2_pin,
    output logic [15:0] result,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    input  logic        io_we,
    input  logic        io_re,
    output logic [31:0] io_rdata,
    output logic        io_ready,
    input  logic        lb_conflict,
    input  logic        retire
);
    logic [7:0]       opr1_q, opr2_q;
    logic [15:0]      result_q;
    logic [31:0]      rdata_q, rd_mux;
    logic             ready_q, freeze_q;
    logic [CNT_W-1:0] cyc_q, lbc_q, ret_q, cyc_d, lbc_d, ret_d;
    logic [2:0]       off;
    logic             hit, wr_res, wr_ctrl, clr, rd_en;
    logic             unused_bits;

    soc_io_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb1 (
        .clk_i(base_clk), .rst_ni(reset), .pin_i(opr1_pin), .opr_o(opr1_q));
    soc_io_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb2 (
        .clk_i(base_clk), .rst_ni(reset), .pin_i(opr2_pin), .opr_o(opr2_q));

    function automatic logic [31:0] zext(input logic [CNT_W-1:0] v);
        logic [31:0] r;
        r = '0;
        r[CNT_W-1:0] = v;
        return r;
    endfunction

    // Byte lanes are ignored: only word offsets 0..5 (0x00..0x14) are mapped.
    assign off         = io_addr[4:2];
    assign hit         = (io_addr[31:5] == BASE_ADDR[31:5]) && (off <= 3'd5);
    assign wr_res      = io_we && hit && (off == 3'd1);
    assign wr_ctrl     = io_we && hit && (off == 3'd5);
    assign clr         = wr_ctrl && io_wdata[0];
    // A simultaneous write wins; the read data register keeps its old value.
    assign rd_en       = io_re && !io_we;
    assign unused_bits = ^{io_addr[1:0], io_wdata[31:16]};

    always_comb begin
        rd_mux = '0;
        if (hit) begin
            case (off)
                3'd0:    rd_mux = {16'h0, opr2_q, opr1_q};
                3'd1:    rd_mux = {16'h0, result_q};
                3'd2:    rd_mux = zext(cyc_q);
                3'd3:    rd_mux = zext(lbc_q);
                3'd4:    rd_mux = zext(ret_q);
                3'd5:    rd_mux = {30'h0, freeze_q, 1'b0};
                default: rd_mux = '0;
            endcase
        end
    end

    // Clear beats both freeze and any same-cycle increment.
    always_comb begin
        cyc_d = cyc_q;
        lbc_d = lbc_q;
        ret_d = ret_q;
        if (clr) begin
            cyc_d = '0;
            lbc_d = '0;
            ret_d = '0;
        end else if (!freeze_q) begin
            cyc_d = cyc_q + CNT_W'(1);
            if (lb_conflict)
                lbc_d = lbc_q + CNT_W'(1);
            if (retire)
                ret_d = ret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge base_clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            freeze_q <= 1'b0;
            cyc_q    <= '0;
            lbc_q    <= '0;
            ret_q    <= '0;
        end else begin
            ready_q <= io_we || io_re;
            if (rd_en)
                rdata_q <= rd_mux;
            if (wr_res)
                result_q <= io_wdata[15:0];
            if (wr_ctrl)
                freeze_q <= io_wdata[1];
            cyc_q <= cyc_d;
            lbc_q <= lbc_d;
            ret_q <= ret_d;
        end
    end

    assign result   = result_q;
    assign io_rdata = rdata_q;
    assign io_ready = ready_q;
endmodule

// File: tb/tb_soc_io_ctrl.sv
// Directed bench for soc_io_ctrl: vector table for register access plus
// hand-written sequences for debounce timing, counters and reset mid-request.
module tb_soc_io_ctrl;
    logic        base_clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  opr1_pin = '0, opr2_pin = '0;
    logic [15:0] result;
    logic [31:0] io_addr = '0, io_wdata = '0, io_rdata;
    logic        io_we = 1'b0, io_re = 1'b0, io_ready;
    logic        lb_conflict = 1'b0, retire = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    soc_io_ctrl dut (
        .base_clk(base_clk), .reset(reset),
        .opr1_pin(opr1_pin), .opr2_pin(opr2_pin), .result(result),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we), .io_re(io_re),
        .io_rdata(io_rdata), .io_ready(io_ready),
        .lb_conflict(lb_conflict), .retire(retire)
    );

    always #5 base_clk = ~base_clk;

    typedef struct {
        bit          we;
        bit          re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [15:0] exp_result;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge base_clk);
        #1;
    endtask

    // One request cycle; ready must be up right after the sampling edge.
    task automatic bus(input bit we, input bit re, input logic [31:0] addr, input logic [31:0] wdata);
        io_we = we;
        io_re = re;
        io_addr = addr;
        io_wdata = wdata;
        tick();
        io_we = 1'b0;
        io_re = 1'b0;
        check("io_ready", {31'h0, io_ready}, 32'h1);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        bus(1'b0, 1'b1, addr, 32'h0);
        check(name, io_rdata, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus(1'b1, 1'b0, addr, data);
    endtask

    // Operands drop to 0xFF for len cycles; OPR must stay at 0x0F03 throughout.
    task automatic glitch(input int len);
        for (int k = 0; k < len + 10; k++) begin
            if (k == 0) begin
                opr1_pin = 8'hFF;
                opr2_pin = 8'hFF;
            end
            if (k == len) begin
                opr1_pin = 8'h03;
                opr2_pin = 8'h0F;
            end
            rd(32'h4000, 32'h0000_0F03, "opr_glitch");
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h4004, 32'hABCD_1234, 32'h0000_0F03, 16'h1234};
        vecs[1]  = '{1'b0, 1'b1, 32'h4004, 32'h0,         32'h0000_1234, 16'h1234};
        vecs[2]  = '{1'b0, 1'b1, 32'h4018, 32'h0,         32'h0,         16'h1234};
        vecs[3]  = '{1'b0, 1'b1, 32'h4040, 32'h0,         32'h0,         16'h1234};
        vecs[4]  = '{1'b0, 1'b1, 32'h4000, 32'h0,         32'h0000_0F03, 16'h1234};
        vecs[5]  = '{1'b1, 1'b0, 32'h4008, 32'hFFFF_FFFF, 32'h0000_0F03, 16'h1234};
        vecs[6]  = '{1'b1, 1'b0, 32'h4000, 32'h0,         32'h0000_0F03, 16'h1234};
        vecs[7]  = '{1'b1, 1'b1, 32'h4004, 32'h5555_BEEF, 32'h0000_0F03, 16'hBEEF};
        vecs[8]  = '{1'b0, 1'b1, 32'h4006, 32'h0,         32'h0000_BEEF, 16'hBEEF};
        vecs[9]  = '{1'b1, 1'b0, 32'h8004, 32'h0000_1111, 32'h0000_BEEF, 16'hBEEF};
        vecs[10] = '{1'b0, 1'b1, 32'h4014, 32'h0,         32'h0,         16'hBEEF};
        vecs[11] = '{1'b1, 1'b0, 32'h4018, 32'h0000_0077, 32'h0,         16'hBEEF};
        vecs[12] = '{1'b0, 1'b1, 32'h4004, 32'h0,         32'h0000_BEEF, 16'hBEEF};

        // Reset state
        #2 reset = 1'b0;
        tick();
        tick();
        check("rst_result", {16'h0, result}, 32'h0);
        check("rst_ready", {31'h0, io_ready}, 32'h0);
        check("rst_rdata", io_rdata, 32'h0);
        reset = 1'b1;
        rd(32'h4004, 32'h0, "first_result");
        rd(32'h4008, 32'h1, "first_cycle");
        tick();
        check("ready_drop", {31'h0, io_ready}, 32'h0);

        // Step response: visible from the read sampled at the end of cycle 6
        opr1_pin = 8'h03;
        opr2_pin = 8'h0F;
        for (int k = 0; k < 9; k++)
            rd(32'h4000, (k >= 6) ? 32'h0000_0F03 : 32'h0, "opr_step");
        glitch(2);
        glitch(3);

        // Register access table
        for (int i = 0; i < 13; i++) begin
            bus(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_rdata", i), io_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_result", i), {16'h0, result}, {16'h0, vecs[i].exp_result});
        end

        // Event counters
        wr(32'h4014, 32'h1);
        lb_conflict = 1'b1;
        retire = 1'b1;
        repeat (7) tick();
        lb_conflict = 1'b0;
        repeat (3) tick();
        retire = 1'b0;
        rd(32'h400C, 32'd7, "lbc_7");
        rd(32'h4010, 32'd10, "retire_10");

        // Clear wins over a same-cycle conflict; a dropped write leaves CYCLE counting
        lb_conflict = 1'b1;
        wr(32'h4014, 32'h1);
        lb_conflict = 1'b0;
        rd(32'h4008, 32'd0, "cyc_after_clr");
        rd(32'h400C, 32'd0, "lbc_after_clr");
        rd(32'h4010, 32'd0, "ret_after_clr");
        wr(32'h4008, 32'h0);
        rd(32'h4008, 32'd4, "cyc_ro_write");

        // Freeze: counts stop after the freezing edge, clear still applies
        wr(32'h4014, 32'h2);
        lb_conflict = 1'b1;
        retire = 1'b1;
        repeat (4) tick();
        rd(32'h4008, 32'd6, "cyc_frozen");
        rd(32'h400C, 32'd0, "lbc_frozen");
        rd(32'h4010, 32'd0, "ret_frozen");
        rd(32'h4014, 32'h2, "ctrl_freeze");
        lb_conflict = 1'b0;
        retire = 1'b0;
        wr(32'h4014, 32'h3);
        rd(32'h4008, 32'd0, "cyc_frozen_clr");
        rd(32'h4014, 32'h2, "ctrl_still_frozen");
        wr(32'h4014, 32'h0);
        rd(32'h4008, 32'd0, "cyc_unfreeze0");
        rd(32'h4008, 32'd1, "cyc_unfreeze1");

        // Reset while a response is showing
        io_addr = 32'h4004;
        io_re = 1'b1;
        tick();
        io_re = 1'b0;
        check("pre_rst_ready", {31'h0, io_ready}, 32'h1);
        reset = 1'b0;
        #1;
        check("rst_async_ready", {31'h0, io_ready}, 32'h0);
        check("rst_async_result", {16'h0, result}, 32'h0);
        tick();
        // Request presented during reset must not produce a response
        io_re = 1'b1;
        tick();
        io_re = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("no_late_ready", {31'h0, io_ready}, 32'h0);
        end
        rd(32'h4004, 32'h0, "post_rst_result");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
